block_encode_a20: RTL and testbench

BLOCK_ENCODE_A20 -- requirements
Module: block_encode_a20

---
 rtl/block_code_a20_pkg.sv | 58 +++++
 rtl/block_encode_a20.sv | 120 ++++++++++++
 tb/tb_block_encode_a20.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/block_code_a20_pkg.sv
// Shared definitions for the (20,A) block code: basis table, FSM states and
// the reference dot-product used by both the encoder and the decoder.
package block_code_a20_pkg;

  localparam int NUM_SYMBOLS = 20;
  localparam int MAX_A       = 13;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    ENCODE = 2'd2,
    SEND   = 2'd3
  } code_state_t;

  // Row i holds M(i,0) in the MSB down to M(i,12) in the LSB.
  localparam logic [MAX_A-1:0] BASIS [NUM_SYMBOLS] = '{
    13'b1100000000110,
    13'b1110000001110,
    13'b1001001011111,
    13'b1011000010111,
    13'b1111000100111,
    13'b1100101110111,
    13'b1010101011111,
    13'b1001100110111,
    13'b1101100101111,
    13'b1011101001111,
    13'b1010011101111,
    13'b1110011010111,
    13'b1001010111111,
    13'b1101010101111,
    13'b1000110100101,
    13'b1100111101101,
    13'b1110111001011,
    13'b1001110010011,
    13'b1101111100000,
    13'b1000011000000
  };

  function automatic logic basis_bit(input int i, input int n);
    return BASIS[i][MAX_A-1-n];
  endfunction

  // info[n] carries a_n; bits at or above len do not contribute.
  function automatic logic [NUM_SYMBOLS-1:0] encode_block(input logic [MAX_A-1:0] info,
                                                          input logic [3:0]       len);
    logic [NUM_SYMBOLS-1:0] code;
    code = '0;
    for (int i = 0; i < NUM_SYMBOLS; i++) begin
      for (int n = 0; n < MAX_A; n++) begin
        if (n < int'(len)) begin
          code[i] = code[i] ^ (info[n] & basis_bit(i, n));
        end
      end
    end
    return code;
  endfunction

endpackage

// File: rtl/block_encode_a20.sv
// (20,A) block encoder: collects A information bits serially, encodes them in
// one cycle and streams out 20 antipodal soft symbols.
module block_encode_a20 #(
  parameter int DATA_WIDTH  = 8,
  parameter int NUM_SYMBOLS = 20
) (
  input  logic                  clk,
  input  logic                  s_axis_aresetn,
  input  logic [3:0]            code_length,
  input  logic                  code_length_valid,
  input  logic                  s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  frame_error
);

  import block_code_a20_pkg::*;

  localparam int IDX_W = $clog2(NUM_SYMBOLS);
  localparam logic [IDX_W-1:0] LAST_SYM = IDX_W'(NUM_SYMBOLS - 1);
  localparam logic [DATA_WIDTH-1:0] SYM_POS = DATA_WIDTH'((1 << (DATA_WIDTH - 1)) - 1);
  localparam logic [DATA_WIDTH-1:0] SYM_NEG = DATA_WIDTH'(0) - SYM_POS;

  code_state_t            state;
  logic [3:0]             a_len;
  logic [3:0]             bit_cnt;
  logic [MAX_A-1:0]       info_reg;
  logic [NUM_SYMBOLS-1:0] code_reg;
  logic [IDX_W-1:0]       sym_idx;
  logic [NUM_SYMBOLS-1:0] codeword;
  logic [IDX_W-1:0]       next_idx;
  logic                   length_ok;
  logic                   final_bit;

  function automatic logic [DATA_WIDTH-1:0] map_symbol(input logic b);
    return b ? SYM_NEG : SYM_POS;
  endfunction

  assign codeword  = encode_block(info_reg, a_len);
  assign next_idx  = sym_idx + IDX_W'(1);
  assign length_ok = (code_length >= 4'd1) && (code_length <= 4'(MAX_A));
  assign final_bit = (bit_cnt == (a_len - 4'd1));

  always_ff @(posedge clk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      state         <= IDLE;
      a_len         <= '0;
      bit_cnt       <= '0;
      info_reg      <= '0;
      code_reg      <= '0;
      sym_idx       <= '0;
      s_axis_tready <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      frame_error   <= 1'b0;
    end else begin
      frame_error <= 1'b0;
      case (state)
        IDLE: begin
          if (code_length_valid && length_ok) begin
            a_len         <= code_length;
            info_reg      <= '0;
            bit_cnt       <= '0;
            s_axis_tready <= 1'b1;
            state         <= LOAD;
          end
        end

        LOAD: begin
          if (s_axis_tvalid) begin
            info_reg[bit_cnt] <= s_axis_tdata;
            bit_cnt           <= bit_cnt + 4'd1;
            // Early tlast leaves the remaining bits at their cleared value of 0.
            if (final_bit) begin
              frame_error   <= ~s_axis_tlast;
              s_axis_tready <= 1'b0;
              state         <= ENCODE;
            end else if (s_axis_tlast) begin
              frame_error   <= 1'b1;
              s_axis_tready <= 1'b0;
              state         <= ENCODE;
            end
          end
        end

        ENCODE: begin
          code_reg      <= codeword;
          sym_idx       <= '0;
          m_axis_tdata  <= map_symbol(codeword[0]);
          m_axis_tvalid <= 1'b1;
          m_axis_tlast  <= (LAST_SYM == '0);
          state         <= SEND;
        end

        SEND: begin
          if (m_axis_tready) begin
            if (sym_idx == LAST_SYM) begin
              m_axis_tvalid <= 1'b0;
              m_axis_tlast  <= 1'b0;
              state         <= IDLE;
            end else begin
              sym_idx      <= next_idx;
              m_axis_tdata <= map_symbol(code_reg[next_idx]);
              m_axis_tlast <= (next_idx == LAST_SYM);
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_block_encode_a20.sv
// Directed bench for block_encode_a20 with hand-computed codewords.
module tb_block_encode_a20;

  logic       clk;
  logic       s_axis_aresetn;
  logic [3:0] code_length;
  logic       code_length_valid;
  logic       s_axis_tdata;
  logic       s_axis_tvalid;
  logic       s_axis_tready;
  logic       s_axis_tlast;
  logic [7:0] m_axis_tdata;
  logic       m_axis_tvalid;
  logic       m_axis_tready;
  logic       m_axis_tlast;
  logic       frame_error;

  int checks = 0;
  int failures = 0;

  block_encode_a20 #(.DATA_WIDTH(8), .NUM_SYMBOLS(20)) dut (
    .clk               (clk),
    .s_axis_aresetn    (s_axis_aresetn),
    .code_length       (code_length),
    .code_length_valid (code_length_valid),
    .s_axis_tdata      (s_axis_tdata),
    .s_axis_tvalid     (s_axis_tvalid),
    .s_axis_tready     (s_axis_tready),
    .s_axis_tlast      (s_axis_tlast),
    .m_axis_tdata      (m_axis_tdata),
    .m_axis_tvalid     (m_axis_tvalid),
    .m_axis_tready     (m_axis_tready),
    .m_axis_tlast      (m_axis_tlast),
    .frame_error       (frame_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Basis rows written as M(i,0)..M(i,12), MSB first.
  logic [12:0] ref_rows [20] = '{
    13'b1100000000110, 13'b1110000001110, 13'b1001001011111, 13'b1011000010111,
    13'b1111000100111, 13'b1100101110111, 13'b1010101011111, 13'b1001100110111,
    13'b1101100101111, 13'b1011101001111, 13'b1010011101111, 13'b1110011010111,
    13'b1001010111111, 13'b1101010101111, 13'b1000110100101, 13'b1100111101101,
    13'b1110111001011, 13'b1001110010011, 13'b1101111100000, 13'b1000011000000
  };

  function automatic logic [19:0] ref_encode(input logic [12:0] bits, input int len);
    logic [19:0] c;
    c = '0;
    for (int i = 0; i < 20; i++)
      for (int n = 0; n < len; n++)
        c[i] = c[i] ^ (bits[n] & ref_rows[i][12-n]);
    return c;
  endfunction

  function automatic logic [7:0] exp_sym(input logic b);
    return b ? 8'h81 : 8'h7F;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input int len);
    code_length       = 4'(len);
    code_length_valid = 1'b1;
    tick();
    code_length_valid = 1'b0;
  endtask

  task automatic send_bit(input string tag, input logic b, input logic last);
    int guard;
    guard         = 0;
    s_axis_tdata  = b;
    s_axis_tlast  = last;
    s_axis_tvalid = 1'b1;
    while (!s_axis_tready && guard < 50) begin
      tick();
      guard++;
    end
    if (guard >= 50) check_eq({tag, "_in_timeout"}, 32'(guard), 32'd0);
    tick();
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  // Sends nbits of bits (a0 first); tlast optionally on the last one sent.
  task automatic send_frame(input string tag, input int len, input logic [12:0] bits,
                            input int nbits, input bit last_on_final, input bit exp_err);
    start(len);
    check_eq({tag, "_tready_load"}, 32'(s_axis_tready), 32'd1);
    for (int k = 0; k < nbits; k++)
      send_bit(tag, bits[k], (k == nbits - 1) && last_on_final);
    check_eq({tag, "_ferr"}, 32'(frame_error), 32'(exp_err));
    check_eq({tag, "_encode_tvalid"}, 32'(m_axis_tvalid), 32'd0);
    check_eq({tag, "_encode_tready"}, 32'(s_axis_tready), 32'd0);
    tick();
    check_eq({tag, "_first_tvalid"}, 32'(m_axis_tvalid), 32'd1);
    check_eq({tag, "_ferr_pulse"}, 32'(frame_error), 32'd0);
  endtask

  // Consumes stop_at beats; a stall keeps tready low 20 of every 30 cycles.
  task automatic run_out(input string tag, input logic [19:0] code, input bit stall,
                         input int stop_at);
    int beat;
    int cyc;
    beat = 0;
    cyc  = 0;
    while (beat < stop_at && cyc < 2000) begin
      m_axis_tready = stall ? ((cyc % 30) >= 20) : 1'b1;
      if (m_axis_tvalid) begin
        check_eq($sformatf("%s_data%0d", tag, beat), 32'(m_axis_tdata), 32'(exp_sym(code[beat])));
        if (m_axis_tready) begin
          check_eq($sformatf("%s_last%0d", tag, beat), 32'(m_axis_tlast), 32'(beat == 19));
          beat++;
        end
      end
      tick();
      cyc++;
    end
    m_axis_tready = 1'b1;
    check_eq({tag, "_beats"}, 32'(beat), 32'(stop_at));
    if (stop_at == 20) begin
      check_eq({tag, "_idle_tvalid"}, 32'(m_axis_tvalid), 32'd0);
      check_eq({tag, "_idle_tlast"}, 32'(m_axis_tlast), 32'd0);
    end
    $display("frame %s: %0d beats in %0d cycles", tag, beat, cyc);
  endtask

  initial begin
    s_axis_aresetn    = 1'b0;
    code_length       = '0;
    code_length_valid = 1'b0;
    s_axis_tdata      = 1'b0;
    s_axis_tvalid     = 1'b0;
    s_axis_tlast      = 1'b0;
    m_axis_tready     = 1'b1;
    tick();
    tick();
    check_eq("rst_tready", 32'(s_axis_tready), 32'd0);
    check_eq("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
    check_eq("rst_tdata", 32'(m_axis_tdata), 32'd0);
    check_eq("rst_ferr", 32'(frame_error), 32'd0);
    s_axis_aresetn = 1'b1;
    tick();

    // Out-of-range lengths are ignored.
    start(0);
    check_eq("len0_ignored", 32'(s_axis_tready), 32'd0);
    start(14);
    check_eq("len14_ignored", 32'(s_axis_tready), 32'd0);

    // A=1, a0=1: column 0 is all ones.
    send_frame("a1", 1, 13'b1, 1, 1'b1, 1'b0);
    run_out("a1", 20'hFFFFF, 1'b0, 20);

    // A=13 all zeros.
    send_frame("a13z", 13, 13'b0, 13, 1'b1, 1'b0);
    run_out("a13z", 20'h00000, 1'b0, 20);

    // A=13 mixed bits with a stalling sink.
    send_frame("a13s", 13, 13'b1011001110101, 13, 1'b1, 1'b0);
    run_out("a13s", ref_encode(13'b1011001110101, 13), 1'b1, 20);

    // A=5 with tlast on the third bit (0,1,0): zero-padded, codeword is column 1.
    send_frame("a5e", 5, 13'b0000000000010, 3, 1'b1, 1'b1);
    run_out("a5e", 20'b0101_1010_1001_0011_0011, 1'b0, 20);

    // A=2 bits 1,1 with no tlast: error flagged, codeword is column 0 ^ column 1.
    send_frame("a2n", 2, 13'b0000000000011, 2, 1'b0, 1'b1);
    run_out("a2n", 20'b1010_0101_0110_1100_1100, 1'b0, 20);

    // Reset at symbol 7 of a frame.
    send_frame("rs", 3, 13'b0000000000111, 3, 1'b1, 1'b0);
    run_out("rs", ref_encode(13'b0000000000111, 3), 1'b0, 7);
    s_axis_aresetn = 1'b0;
    #1;
    check_eq("rs_async_tvalid", 32'(m_axis_tvalid), 32'd0);
    check_eq("rs_async_tdata", 32'(m_axis_tdata), 32'd0);
    check_eq("rs_async_tlast", 32'(m_axis_tlast), 32'd0);
    tick();
    tick();
    s_axis_aresetn = 1'b1;
    s_axis_tvalid  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check_eq($sformatf("rs_no_tvalid%0d", k), 32'(m_axis_tvalid), 32'd0);
      check_eq($sformatf("rs_no_tready%0d", k), 32'(s_axis_tready), 32'd0);
    end
    s_axis_tvalid = 1'b0;

    // A=4 bits 1,0,0,1: column 0 ^ column 3.
    send_frame("a4", 4, 13'b0000000001001, 4, 1'b1, 1'b0);
    run_out("a4", 20'b1001_1100_1100_0110_0011, 1'b0, 20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
